// File: rtl/datastore_entry_ctrl.sv
// Keyboard-entry sequencer: turns decoded key events into the nibble datastore write stream.
// Optional backspace editing is compiled in with `define DATASTORE_BACKSPACE_EN.
module datastore_entry_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_hex,
  input  logic       key_is_hex,
  input  logic       key_enter,
  input  logic       key_backspace,
  input  logic       key_clear,
  input  logic       done_ack,
  output logic [3:0] ps2data_out,
  output logic [4:0] index,
  output logic       write_enable,
  output logic [5:0] count,
  output logic       entry_done,
  output logic       reject
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_FULL  = 2'd1,
    ST_DONE  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic [4:0] index_q, index_d;
  logic [3:0] data_q, data_d;
  logic       we_q, we_d;
  logic       done_q, done_d;
  logic       reject_q, reject_d;
  logic       ev_clear, ev_enter, ev_bs, ev_hex;

  // Slot the next digit lands in; a full block parks the pointer on slot 0.
  function automatic logic [4:0] next_slot(input logic [5:0] c);
    logic [5:0] diff;
    diff = 6'd31 - c;
    if (c == 6'd32) begin
      return 5'd0;
    end else begin
      return diff[4:0];
    end
  endfunction

  assign ev_clear = key_valid & key_clear;
  assign ev_enter = key_valid & ~key_clear & key_enter;
`ifdef DATASTORE_BACKSPACE_EN
  assign ev_bs    = key_valid & ~key_clear & ~key_enter & key_backspace;
  assign ev_hex   = key_valid & ~key_clear & ~key_enter & ~key_backspace & key_is_hex;
`else
  logic unused_backspace;
  assign unused_backspace = key_backspace;
  assign ev_bs    = 1'b0;
  assign ev_hex   = key_valid & ~key_clear & ~key_enter & key_is_hex;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ENTRY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ENTRY: begin
        if (ev_clear) begin
          state_d = ST_CLEAR;
        end else if (ev_enter && (count_q != 6'd0)) begin
          state_d = ST_DONE;
        end else if (ev_hex && (count_q == 6'd31)) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_ENTRY;
        end
      end
      ST_FULL: begin
        if (ev_clear) begin
          state_d = ST_CLEAR;
        end else if (ev_enter) begin
          state_d = ST_DONE;
        end else if (ev_bs) begin
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_FULL;
        end
      end
      ST_DONE: begin
        if (ev_clear || done_ack) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_CLEAR: begin
        if (index_q == 5'd31) begin
          state_d = ST_ENTRY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  // Output/datapath next values; the wipe sweep writes slot 0 on the edge that enters CLEAR.
  always_comb begin
    count_d  = count_q;
    index_d  = next_slot(count_q);
    data_d   = data_q;
    we_d     = 1'b0;
    reject_d = 1'b0;
    done_d   = (state_d == ST_DONE);
    case (state_q)
      ST_ENTRY: begin
        if (ev_clear) begin
          we_d    = 1'b1;
          index_d = 5'd0;
          data_d  = 4'd0;
        end else if (ev_enter) begin
          reject_d = (count_q == 6'd0);
        end else if (ev_bs) begin
          if (count_q == 6'd0) begin
            reject_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            index_d = 5'd0 - count_q[4:0];
            data_d  = 4'd0;
            count_d = count_q - 6'd1;
          end
        end else if (ev_hex) begin
          we_d    = 1'b1;
          index_d = next_slot(count_q);
          data_d  = key_hex;
          count_d = count_q + 6'd1;
        end else begin
          we_d = 1'b0;
        end
      end
      ST_FULL: begin
        if (ev_clear) begin
          we_d    = 1'b1;
          index_d = 5'd0;
          data_d  = 4'd0;
        end else if (ev_enter) begin
          we_d = 1'b0;
        end else if (ev_bs) begin
          we_d    = 1'b1;
          index_d = 5'd0;
          data_d  = 4'd0;
          count_d = 6'd31;
        end else begin
          reject_d = ev_hex;
        end
      end
      ST_DONE: begin
        reject_d = ~ev_clear & (ev_enter | ev_bs | ev_hex);
        if (ev_clear || done_ack) begin
          we_d    = 1'b1;
          index_d = 5'd0;
          data_d  = 4'd0;
        end else begin
          we_d = 1'b0;
        end
      end
      ST_CLEAR: begin
        reject_d = ev_clear | ev_enter | ev_bs | ev_hex;
        if (index_q == 5'd31) begin
          count_d = 6'd0;
          index_d = 5'd31;
        end else begin
          we_d    = 1'b1;
          index_d = index_q + 5'd1;
          data_d  = 4'd0;
        end
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 6'd0;
      index_q  <= 5'd31;
      data_q   <= 4'd0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      index_q  <= index_d;
      data_q   <= data_d;
      we_q     <= we_d;
      done_q   <= done_d;
      reject_q <= reject_d;
    end
  end

  assign ps2data_out  = data_q;
  assign index        = index_q;
  assign write_enable = we_q;
  assign count        = count_q;
  assign entry_done   = done_q;
  assign reject       = reject_q;

endmodule

// File: tb/tb_datastore_entry_ctrl.sv
// Self-checking bench for datastore_entry_ctrl: directed plan plus random key traffic
// against an event-level model of the 32-slot entry buffer.
module tb_datastore_entry_ctrl;

`ifdef DATASTORE_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_hex;
  logic       key_is_hex;
  logic       key_enter;
  logic       key_backspace;
  logic       key_clear;
  logic       done_ack;
  logic [3:0] ps2data_out;
  logic [4:0] index;
  logic       write_enable;
  logic [5:0] count;
  logic       entry_done;
  logic       reject;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state: digits entered, block-complete flag, wipe progress (0 = idle).
  int         m_count = 0;
  bit         m_done  = 1'b0;
  int         m_sweep = 0;
  logic [3:0] m_mem   [32];
  logic [3:0] dut_mem [32];
  bit         e_we, e_rej;
  logic [4:0] e_idx;
  logic [3:0] e_data;

  datastore_entry_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_hex      (key_hex),
    .key_is_hex   (key_is_hex),
    .key_enter    (key_enter),
    .key_backspace(key_backspace),
    .key_clear    (key_clear),
    .done_ack     (done_ack),
    .ps2data_out  (ps2data_out),
    .index        (index),
    .write_enable (write_enable),
    .count        (count),
    .entry_done   (entry_done),
    .reject       (reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic m_write(input int slot, input logic [3:0] val);
    e_we   = 1'b1;
    e_idx  = 5'(slot);
    e_data = val;
    m_mem[slot] = val;
  endtask

  task automatic model_step(input bit rst, input bit v, input bit ih, input bit ent,
                            input bit bs, input bit clr, input bit ack, input logic [3:0] hx);
    bit a_clr, a_ent, a_bs, a_hex, keyev;
    e_we  = 1'b0;
    e_rej = 1'b0;
    if (rst) begin
      m_count = 0;
      m_done  = 1'b0;
      m_sweep = 0;
      e_data  = 4'd0;
      e_idx   = 5'd31;
      for (int i = 0; i < 32; i++) m_mem[i] = 4'd0;
    end else begin
      a_clr = v && clr;
      a_ent = v && !clr && ent;
      a_bs  = BS_EN && v && !clr && !ent && bs;
      a_hex = v && !clr && !ent && !(BS_EN && bs) && ih;
      keyev = a_clr || a_ent || a_bs || a_hex;
      if (m_sweep != 0) begin
        e_rej = keyev;
        if (m_sweep == 32) begin
          m_sweep = 0;
          m_count = 0;
        end else begin
          m_write(m_sweep, 4'd0);
          m_sweep++;
        end
      end else if (m_done) begin
        e_rej = !a_clr && (a_ent || a_bs || a_hex);
        if (a_clr || ack) begin
          m_done = 1'b0;
          m_write(0, 4'd0);
          m_sweep = 1;
        end
      end else if (a_clr) begin
        m_write(0, 4'd0);
        m_sweep = 1;
      end else if (a_ent) begin
        if (m_count == 0) e_rej = 1'b1;
        else m_done = 1'b1;
      end else if (a_bs) begin
        if (m_count == 0) e_rej = 1'b1;
        else begin
          m_write(32 - m_count, 4'd0);
          m_count--;
        end
      end else if (a_hex) begin
        if (m_count == 32) e_rej = 1'b1;
        else begin
          m_write(31 - m_count, hx);
          m_count++;
        end
      end
      if (!e_we) e_idx = (m_count == 32) ? 5'd0 : 5'(31 - m_count);
    end
  endtask

  // One clock: drive at the falling edge, let the DUT act on the rising edge, compare at the next falling edge.
  task automatic tick(input bit rst, input bit v, input bit ih, input bit ent,
                      input bit bs, input bit clr, input bit ack, input logic [3:0] hx);
    reset = rst; key_valid = v; key_is_hex = ih; key_enter = ent;
    key_backspace = bs; key_clear = clr; done_ack = ack; key_hex = hx;
    model_step(rst, v, ih, ent, bs, clr, ack, hx);
    @(posedge clk);
    @(negedge clk);
    check_eq("write_enable", 32'(write_enable), 32'(e_we));
    check_eq("index", 32'(index), 32'(e_idx));
    check_eq("ps2data_out", 32'(ps2data_out), 32'(e_data));
    check_eq("count", 32'(count), 32'(m_count));
    check_eq("entry_done", 32'(entry_done), 32'(m_done));
    check_eq("reject", 32'(reject), 32'(e_rej));
    if (rst) begin
      for (int i = 0; i < 32; i++) dut_mem[i] = 4'd0;
    end else if (write_enable) begin
      dut_mem[index] = ps2data_out;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic hexkey(input logic [3:0] h);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++) check_eq(tag, dut_mem[i], m_mem[i]);
  endtask

  initial begin
    bit rv, ih, en, bs, cl, ak, rs;
    reset = 1'b1; key_valid = 1'b0; key_hex = 4'd0; key_is_hex = 1'b0;
    key_enter = 1'b0; key_backspace = 1'b0; key_clear = 1'b0; done_ack = 1'b0;
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = 4'd0;
      dut_mem[i] = 4'd0;
    end
    @(negedge clk);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("rst_index", 32'(index), 32'd31);
    idle(1);

    hexkey(4'h3);
    check_eq("k3_idx", 32'(index), 32'd31);
    hexkey(4'hA);
    check_eq("kA_idx", 32'(index), 32'd30);
    hexkey(4'hF);
    check_eq("kF_idx", 32'(index), 32'd29);
    check_eq("k3AF_count", 32'(count), 32'd3);
    check_mem("mem_3AF");

    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(32);

    for (int i = 0; i < 32; i++) hexkey(4'(i));
    check_eq("full_count", 32'(count), 32'd32);
    hexkey(4'h7);
    check_eq("full_reject", 32'(reject), 32'd1);
    check_eq("full_no_write", 32'(write_enable), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("done_rise", 32'(entry_done), 32'd1);
    check_mem("mem_full");
    hexkey(4'h2);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    check_eq("done_fall", 32'(entry_done), 32'd0);
    idle(4);
    hexkey(4'h5);
    check_eq("sweep_reject", 32'(reject), 32'd1);
    idle(27);
    check_eq("sweep_end_count", 32'(count), 32'd0);
    check_eq("sweep_end_index", 32'(index), 32'd31);
    check_mem("mem_wiped");

    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("enter0_reject", 32'(reject), 32'd1);
    check_eq("enter0_done", 32'(entry_done), 32'd0);

    hexkey(4'h1);
    hexkey(4'h2);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("bs_count", 32'(count), BS_EN ? 32'd1 : 32'd2);
    hexkey(4'h9);
    check_eq("bs_next_idx", 32'(index), BS_EN ? 32'd30 : 32'd29);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(32);

    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC);
    check_eq("clrhex_idx", 32'(index), 32'd0);
    check_eq("clrhex_data", 32'(ps2data_out), 32'd0);
    idle(8);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("midrst_we", 32'(write_enable), 32'd0);
    check_eq("midrst_count", 32'(count), 32'd0);
    idle(1);

    for (int n = 0; n < 3000; n++) begin
      rv = ($urandom_range(99) < 70);
      ih = ($urandom_range(99) < 80);
      en = ($urandom_range(99) < 4);
      bs = ($urandom_range(99) < 10);
      cl = ($urandom_range(99) < 2);
      ak = ($urandom_range(99) < 10);
      rs = ($urandom_range(999) < 2);
      tick(rs, rv, ih, en, bs, cl, ak, 4'($urandom_range(15)));
    end
    check_mem("mem_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
